// File: rtl/controller_types_pkg.sv
// Shared encodings for the multicycle controller: FSM states, data-processing
// commands, alu_control values and datapath mux selects.
package controller_types_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // funct[4:1] command field
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the data-processing command to alu_control,
// the unconditioned flag-write enables and register-write suppression.
module alu_decoder
    import controller_types_pkg::*;
(
    input  logic [4:0] funct,
    input  logic       alu_op,
    output logic [1:0] alu_control,
    output logic [1:0] flag_write,
    output logic       no_write
);

    alu_ctrl_t ctl;
    logic      is_cmp;

    always_comb begin
        ctl         = ALU_ADD;
        no_write    = 1'b0;
        is_cmp      = 1'b0;
        alu_control = '0;
        flag_write  = '0;

        case (funct[4:1])
            CMD_ADD: ctl = ALU_ADD;
            CMD_SUB: ctl = ALU_SUB;
            CMD_CMP: begin
                ctl      = ALU_SUB;
                no_write = 1'b1;
                is_cmp   = 1'b1;
            end
            CMD_AND: ctl = ALU_AND;
            CMD_ORR: ctl = ALU_ORR;
            default: no_write = 1'b1;
        endcase

        // Suppression is independent of alu_op so the write-back state can use it.
        if (alu_op) begin
            alu_control = ctl;
            if (is_cmp)
                flag_write = '1;
            else
                flag_write = {funct[0], funct[0] & ~ctl[1]};
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle ARM-subset datapath: sequences fetch,
// decode, memory, execute and branch steps and drives mux selects and enables.
module multicycle_controller
    import controller_types_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] destination,
    output logic [1:0] potential_flag_write,
    output logic       potential_program_counter,
    output logic       potential_register_write,
    output logic       potential_memory_write,
    output logic       next_pc,
    output logic       ir_write,
    output logic       address_source,
    output logic       alu_source_a,
    output logic [1:0] alu_source_b,
    output logic [1:0] result_source,
    output logic [1:0] immediate_source,
    output logic [1:0] register_source,
    output logic [1:0] alu_control
);

    state_t state, state_next;
    logic   alu_op;
    logic   no_write;
    logic   branch;

    alu_decoder u_alu_decoder (
        .funct       (funct[4:0]),
        .alu_op      (alu_op),
        .alu_control (alu_control),
        .flag_write  (potential_flag_write),
        .no_write    (no_write)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        ir_write                 = 1'b0;
        next_pc                  = 1'b0;
        address_source           = 1'b0;
        alu_source_a             = 1'b0;
        alu_source_b             = SRC_B_REG;
        result_source            = RES_ALUOUT;
        alu_op                   = 1'b0;
        branch                   = 1'b0;
        potential_register_write = 1'b0;
        potential_memory_write   = 1'b0;

        case (state)
            FETCH: begin
                ir_write      = 1'b1;
                next_pc       = 1'b1;
                alu_source_a  = 1'b1;
                alu_source_b  = SRC_B_FOUR;
                result_source = RES_ALU;
            end
            DECODE: begin
                alu_source_a  = 1'b1;
                alu_source_b  = SRC_B_FOUR;
                result_source = RES_ALU;
            end
            MEMADR:   alu_source_b = SRC_B_IMM;
            MEMREAD:  address_source = 1'b1;
            MEMWB: begin
                result_source            = RES_DATA;
                potential_register_write = 1'b1;
            end
            MEMWRITE: begin
                address_source         = 1'b1;
                potential_memory_write = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                alu_source_b = SRC_B_IMM;
                alu_op       = 1'b1;
            end
            ALUWB:    potential_register_write = ~no_write;
            BRANCH: begin
                alu_source_b  = SRC_B_IMM;
                result_source = RES_ALU;
                branch        = 1'b1;
            end
            default: ;
        endcase
    end

    // A register write to R15 redirects the PC.
    assign potential_program_counter = branch
        | (potential_register_write & (destination == 4'b1111));

    assign immediate_source = op;
    assign register_source  = {op == 2'b01, op == 2'b10};

endmodule
